// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Responder (slave) end of the data_sram request/response interface.
//   Requests are accepted with addr_ok, writes land in an internal
//   word-addressed RAM under byte strobes, and every accepted request
//   produces exactly one data_ok pulse, in acceptance order, no earlier
//   than LATENCY cycles after acceptance.
//
//   Optional build macro: DATA_SRAM_RESPONDER_STALL_EN
//     When defined, a 4-bit LFSR (x^4+x^3+1, seed 4'b1001) additionally
//     gates addr_ok with LFSR[0] so the master's hold logic is stressed.
//
// Ports
//   clk                clock, all logic on posedge
//   reset              synchronous, active-high reset
//   data_sram_req      request valid
//   data_sram_wr       1 = write, 0 = read
//   data_sram_size     access size (informational, not used)
//   data_sram_wstrb    byte-lane write enables
//   data_sram_addr     byte address
//   data_sram_wdata    lane-aligned write data
//   data_sram_addr_ok  request accepted when high together with req
//   data_sram_data_ok  one response completes this cycle
//   data_sram_rdata    read word, zero unless data_ok
module data_sram_responder #(
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = $clog2(OUTSTANDING);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;

  logic [31:0]       q_rdata [OUTSTANDING];
  logic [3:0]        q_cnt   [OUTSTANDING];
  logic [OUTSTANDING-1:0] q_valid;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;

  logic              push;
  logic              pop;
  logic              slot_free;

  // Size and the bits outside the word index never affect behaviour.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2],
                         data_sram_addr[1:0]};

  assign idx       = data_sram_addr[ADDR_W+1:2];
  assign slot_free = (count < (PW+1)'(OUTSTANDING));

`ifdef DATA_SRAM_RESPONDER_STALL_EN
  logic [3:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= 4'b1001;
    else       lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

  assign data_sram_addr_ok = !reset && slot_free && lfsr[0];
`else
  assign data_sram_addr_ok = !reset && slot_free;
`endif

  assign push = data_sram_req && data_sram_addr_ok;

  // Head is answered as soon as its countdown has expired; no back-pressure.
  assign data_sram_data_ok = !reset && q_valid[head] && (q_cnt[head] == 4'd0);
  assign data_sram_rdata   = data_sram_data_ok ? q_rdata[head] : 32'd0;
  assign pop               = data_sram_data_ok;

  // RAM is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (push && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (q_valid[i] && (q_cnt[i] != 4'd0)) q_cnt[i] <= q_cnt[i] - 4'd1;
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      // Read data is captured at acceptance, so it sees all earlier writes.
      if (push) begin
        q_valid[tail] <= 1'b1;
        q_rdata[tail] <= data_sram_wr ? 32'd0 : mem[idx];
        q_cnt[tail]   <= 4'(LATENCY - 1);
        tail          <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
